// File: rtl/instr_readback_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_readback_checker_if                                                |
// | Register-file read port used by the readback checker.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface instr_readback_checker_if;
  logic [4:0]   read_pointer;
  logic [131:0] instruction_word;

  modport master (output read_pointer, input instruction_word);
  modport slave  (input read_pointer, output instruction_word);
endinterface
`default_nettype wire

// File: rtl/instr_readback_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_readback_checker                                                   |
// | Sweeps register-file entries, recomputes each stored result, and counts  |
// | matches, mismatches and skipped divide/modulo-by-zero entries.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_readback_checker #(
  parameter int READ_LAT = 2,
  parameter int DEPTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [4:0]               first_ptr,
  input  logic [5:0]               count,
  instr_readback_checker_if.master rf,
  output logic                     busy,
  output logic                     done,
  output logic [5:0]               pass_cnt,
  output logic [5:0]               fail_cnt,
  output logic [5:0]               skip_cnt,
  output logic                     err_valid,
  output logic [4:0]               err_ptr,
  output logic [63:0]              err_expected,
  output logic [63:0]              err_actual
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_check = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [3:0] c_op_zero  = 4'd0;
  localparam logic [3:0] c_op_passa = 4'd1;
  localparam logic [3:0] c_op_passb = 4'd2;
  localparam logic [3:0] c_op_add   = 4'd3;
  localparam logic [3:0] c_op_sub   = 4'd4;
  localparam logic [3:0] c_op_mult  = 4'd5;
  localparam logic [3:0] c_op_div   = 4'd6;
  localparam logic [3:0] c_op_mod   = 4'd7;

  localparam logic [2:0] c_read_lat = 3'(READ_LAT);
  localparam logic [4:0] c_last_ptr = 5'(DEPTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_wait_cnt;
  logic [5:0]         r_remaining;
  logic [4:0]         r_read_ptr;
  logic [4:0]         w_ptr_next;

  logic [3:0]         w_opcode;
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_b_safe;
  logic signed [63:0] w_result;
  logic signed [63:0] w_expected;
  logic               w_b_zero;
  logic               w_illegal;
  logic               w_skip;
  logic               w_mismatch;

  assign rf.read_pointer = r_read_ptr;
  assign w_ptr_next      = (r_read_ptr == c_last_ptr) ? 5'd0 : r_read_ptr + 5'd1;

  // Operands are sign-extended so every opcode is evaluated exactly at 64 bits.
  always_comb begin
    w_opcode   = rf.instruction_word[131:128];
    w_a        = {{32{rf.instruction_word[127]}}, rf.instruction_word[127:96]};
    w_b        = {{32{rf.instruction_word[95]}}, rf.instruction_word[95:64]};
    w_result   = rf.instruction_word[63:0];
    w_b_zero   = (rf.instruction_word[95:64] == 32'd0);
    w_b_safe   = w_b_zero ? 64'sd1 : w_b;
    w_illegal  = w_opcode[3];
    w_expected = '0;
    case (w_opcode)
      c_op_zero:  w_expected = '0;
      c_op_passa: w_expected = w_a;
      c_op_passb: w_expected = w_b;
      c_op_add:   w_expected = w_a + w_b;
      c_op_sub:   w_expected = w_a - w_b;
      c_op_mult:  w_expected = w_a * w_b;
      c_op_div:   w_expected = w_a / w_b_safe;
      c_op_mod:   w_expected = w_a % w_b_safe;
      default:    w_expected = '0;
    endcase
    w_skip     = w_b_zero && ((w_opcode == c_op_div) || (w_opcode == c_op_mod));
    w_mismatch = w_illegal || (w_expected != w_result);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = (count == 6'd0) ? c_st_done : c_st_wait;
      c_st_wait:  if (r_wait_cnt <= 3'd1) w_state_nxt = c_st_check;
      c_st_check: w_state_nxt = (r_remaining == 6'd1) ? c_st_done : c_st_wait;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_wait) || (r_state == c_st_check);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt   <= '0;
      r_remaining  <= '0;
      r_read_ptr   <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      skip_cnt     <= '0;
      err_valid    <= 1'b0;
      err_ptr      <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            skip_cnt <= '0;
            if (count != 6'd0) begin
              r_remaining <= count;
              r_read_ptr  <= first_ptr;
              r_wait_cnt  <= c_read_lat;
            end
          end
        end
        c_st_wait: begin
          if (r_wait_cnt > 3'd1) r_wait_cnt <= r_wait_cnt - 3'd1;
        end
        c_st_check: begin
          if (w_skip) begin
            skip_cnt <= skip_cnt + 6'd1;
          end else if (w_mismatch) begin
            fail_cnt     <= fail_cnt + 6'd1;
            err_valid    <= 1'b1;
            err_ptr      <= r_read_ptr;
            err_expected <= w_expected;
            err_actual   <= w_result;
          end else begin
            pass_cnt <= pass_cnt + 6'd1;
          end
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining != 6'd1) begin
            r_read_ptr <= w_ptr_next;
            r_wait_cnt <= c_read_lat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_readback_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_readback_checker                                                |
// | Directed bench with a READ_LAT-deep register-file model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_readback_checker;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_ptr = '0;
  logic [5:0]  count = '0;
  logic        busy, done, err_valid;
  logic [5:0]  pass_cnt, fail_cnt, skip_cnt;
  logic [4:0]  err_ptr;
  logic [63:0] err_expected, err_actual;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0, err_pulses = 0, busy_cycles = 0;
  logic [4:0] ptr_seq[$];

  logic [131:0] mem [0:31];
  logic [4:0]   pipe [0:RL-1];

  instr_readback_checker_if rf_if();

  instr_readback_checker #(.READ_LAT(RL), .DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr), .count(count),
    .rf(rf_if), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .skip_cnt(skip_cnt), .err_valid(err_valid), .err_ptr(err_ptr),
    .err_expected(err_expected), .err_actual(err_actual)
  );

  always #5 clk = ~clk;

  // Register file: data for an address appears RL clocks after the address.
  always @(posedge clk) begin
    pipe[0] <= rf_if.read_pointer;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign rf_if.instruction_word = mem[pipe[RL-1]];

  // Posedge sampling sees the values of the cycle just ending.
  always @(posedge clk) begin
    if (done) done_pulses++;
    if (err_valid) err_pulses++;
    if (busy) begin
      busy_cycles++;
      if (ptr_seq.size() == 0 || rf_if.read_pointer != ptr_seq[$]) ptr_seq.push_back(rf_if.read_pointer);
    end
  end

  function automatic logic [131:0] mk(input logic [3:0] op, input int a, input int b, input longint r);
    return {op, a, b, r};
  endfunction

  task automatic clear_mon();
    done_pulses = 0; err_pulses = 0; busy_cycles = 0; ptr_seq.delete();
  endtask

  task automatic run_sweep(input logic [4:0] fp, input logic [5:0] cnt, output int edges, output bit got);
    @(negedge clk);
    start = 1'b1; first_ptr = fp; count = cnt;
    clear_mon();
    edges = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); edges++;
      @(negedge clk); start = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err_valid !== 1'b0) begin failures++;
      $display("FAIL reset.flags busy=%b done=%b err_valid=%b required 0 0 0", busy, done, err_valid); end
    checks++; if (pass_cnt !== 6'd0 || fail_cnt !== 6'd0 || skip_cnt !== 6'd0) begin failures++;
      $display("FAIL reset.counters pass=%0d fail=%0d skip=%0d required 0 0 0", pass_cnt, fail_cnt, skip_cnt); end
    checks++; if (rf_if.read_pointer !== 5'd0 || err_ptr !== 5'd0 || err_expected !== 64'd0 || err_actual !== 64'd0) begin failures++;
      $display("FAIL reset.regs rp=%0d err_ptr=%0d exp=%h act=%h required all 0", rf_if.read_pointer, err_ptr, err_expected, err_actual); end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pass_sweep();
    int edges; bit got;
    mem[0] = mk(4'd3, 5, 3, 64'sd8);
    mem[1] = mk(4'd4, 2, 7, -64'sd5);
    mem[2] = mk(4'd5, -4, 6, -64'sd24);
    run_sweep(5'd0, 6'd3, edges, got);
    checks++; if (!got || edges != 10) begin failures++;
      $display("FAIL pass_sweep.latency got_done=%0d edges=%0d required done at 10", got, edges); end
    checks++; if (pass_cnt !== 6'd3 || fail_cnt !== 6'd0 || skip_cnt !== 6'd0 || busy !== 1'b0) begin failures++;
      $display("FAIL pass_sweep.counts pass=%0d fail=%0d skip=%0d busy=%b required 3 0 0 0", pass_cnt, fail_cnt, skip_cnt, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || done_pulses != 1 || busy_cycles != 9 || err_pulses != 0) begin failures++;
      $display("FAIL pass_sweep.pulses done=%b done_pulses=%0d busy_cycles=%0d err_pulses=%0d required 0 1 9 0", done, done_pulses, busy_cycles, err_pulses); end
  endtask

  task automatic test_mismatch();
    int edges; bit got;
    mem[4] = mk(4'd3, 1, 1, 64'sd3);
    run_sweep(5'd4, 6'd1, edges, got);
    @(negedge clk);
    checks++; if (!got || err_pulses != 1 || fail_cnt !== 6'd1 || pass_cnt !== 6'd0) begin failures++;
      $display("FAIL mismatch.counts got_done=%0d err_pulses=%0d fail=%0d pass=%0d required 1 1 1 0", got, err_pulses, fail_cnt, pass_cnt); end
    checks++; if (err_ptr !== 5'd4 || err_expected !== 64'd2 || err_actual !== 64'd3) begin failures++;
      $display("FAIL mismatch.err ptr=%0d exp=%h act=%h required 4 2 3", err_ptr, err_expected, err_actual); end
  endtask

  task automatic test_wrap();
    int edges; bit got;
    mem[30] = mk(4'd0, 11, 12, 64'sd0);
    mem[31] = mk(4'd2, 1, -9, -64'sd9);
    run_sweep(5'd30, 6'd4, edges, got);
    checks++; if (!got || (pass_cnt + fail_cnt + skip_cnt) != 4 || pass_cnt !== 6'd4) begin failures++;
      $display("FAIL wrap.counts got_done=%0d pass=%0d fail=%0d skip=%0d required pass 4 total 4", got, pass_cnt, fail_cnt, skip_cnt); end
    checks++; if (ptr_seq.size() != 4 || ptr_seq[0] != 5'd30 || ptr_seq[1] != 5'd31 || ptr_seq[2] != 5'd0 || ptr_seq[3] != 5'd1) begin failures++;
      $display("FAIL wrap.sequence got %p required 30 31 0 1", ptr_seq); end
  endtask

  task automatic test_skip();
    int edges; bit got;
    mem[8] = mk(4'd6, 9, 0, 64'sd5);
    mem[9] = mk(4'd7, -7, 2, -64'sd1);
    run_sweep(5'd8, 6'd2, edges, got);
    @(negedge clk);
    checks++; if (!got || skip_cnt !== 6'd1 || pass_cnt !== 6'd1 || fail_cnt !== 6'd0 || err_pulses != 0) begin failures++;
      $display("FAIL skip.counts got_done=%0d skip=%0d pass=%0d fail=%0d err_pulses=%0d required 1 1 0 0", got, skip_cnt, pass_cnt, fail_cnt, err_pulses); end
  endtask

  task automatic test_div_illegal();
    int edges; bit got;
    mem[10] = mk(4'd6, -7, 2, -64'sd3);
    mem[11] = mk(4'd9, 4, 4, 64'sd0);
    run_sweep(5'd10, 6'd2, edges, got);
    @(negedge clk);
    checks++; if (!got || pass_cnt !== 6'd1 || fail_cnt !== 6'd1 || err_pulses != 1) begin failures++;
      $display("FAIL div_illegal.counts got_done=%0d pass=%0d fail=%0d err_pulses=%0d required 1 1 1", got, pass_cnt, fail_cnt, err_pulses); end
    checks++; if (err_ptr !== 5'd11 || err_expected !== 64'd0 || err_actual !== 64'd0) begin failures++;
      $display("FAIL div_illegal.err ptr=%0d exp=%h act=%h required 11 0 0", err_ptr, err_expected, err_actual); end
  endtask

  task automatic test_reset_mid_sweep();
    int edges; bit got; bit seen = 1'b0;
    for (int i = 12; i < 17; i++) mem[i] = mk(4'd3, i, 1, longint'(i + 1));
    @(negedge clk); start = 1'b1; first_ptr = 5'd12; count = 6'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (busy && rf_if.read_pointer == 5'd13) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++;
      $display("FAIL reset_mid.reach_second read_pointer=%0d required 13 while busy", rf_if.read_pointer); end
    clear_mon();
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pass_cnt !== 6'd0 || rf_if.read_pointer !== 5'd0 || done !== 1'b0) begin failures++;
      $display("FAIL reset_mid.immediate busy=%b pass=%0d rp=%0d done=%b required 0 0 0 0", busy, pass_cnt, rf_if.read_pointer, done); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (done_pulses != 0 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_mid.abandon done_pulses=%0d busy=%b required 0 0", done_pulses, busy); end
    run_sweep(5'd12, 6'd2, edges, got);
    checks++; if (!got || edges != 7 || pass_cnt !== 6'd2 || fail_cnt !== 6'd0) begin failures++;
      $display("FAIL reset_mid.restart got_done=%0d edges=%0d pass=%0d fail=%0d required 1 7 2 0", got, edges, pass_cnt, fail_cnt); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    @(negedge clk); start = 1'b1; first_ptr = 5'd0; count = 6'd3;
    clear_mon();
    @(negedge clk); first_ptr = 5'd20; count = 6'd1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checks++; if (!got || pass_cnt !== 6'd3 || ptr_seq.size() != 3 || ptr_seq[0] != 5'd0 || ptr_seq[2] != 5'd2) begin failures++;
      $display("FAIL held_start.sweep got_done=%0d pass=%0d seq=%p required pass 3 seq 0 1 2", got, pass_cnt, ptr_seq); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || done_pulses != 1 || busy_cycles != 9) begin failures++;
      $display("FAIL held_start.pulses done=%b done_pulses=%0d busy_cycles=%0d required 0 1 9", done, done_pulses, busy_cycles); end
    @(negedge clk); start = 1'b1; first_ptr = 5'd5; count = 6'd0;
    clear_mon();
    @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 6'd0) begin failures++;
      $display("FAIL count_zero.done done=%b busy=%b pass=%0d required 1 0 0", done, busy, pass_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || done_pulses != 1 || busy_cycles != 0) begin failures++;
      $display("FAIL count_zero.pulses done=%b done_pulses=%0d busy_cycles=%0d required 0 1 0", done, done_pulses, busy_cycles); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mk(4'd0, 0, 0, 64'sd0);
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    test_reset();
    test_pass_sweep();
    test_mismatch();
    test_wrap();
    test_skip();
    test_div_illegal();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_readback_checker.md
INSTR_READBACK_CHECKER -- requirements
Module: instr_readback_checker

Interface
Parameters:
REQ-001 The block SHALL have parameter READ_LAT, default 2: clocks from a read_pointer change to valid instruction_word, legal range 1..7.
REQ-002 The block SHALL have parameter DEPTH, default 32: register file entries; read_pointer is 5 bits.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on posedge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a readback sweep.
REQ-006 The block SHALL have port first_ptr, input, 5 bits: first entry to check.
REQ-007 The block SHALL have port count, input, 6 bits: number of entries to check, 0..32.
REQ-008 The block SHALL have port instruction_word, input, 132 bits, with this layout:
- [131:128] opcode
- [127:96] operand_a, signed
- [95:64] operand_b, signed
- [63:0] result, signed
REQ-009 The block SHALL have port read_pointer, output, 5 bits: register file read address.
REQ-010 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep ends.
REQ-012 The block SHALL have port pass_cnt, output, 6 bits: entries that matched.
REQ-013 The block SHALL have port fail_cnt, output, 6 bits: entries that mismatched.
REQ-014 The block SHALL have port skip_cnt, output, 6 bits: entries with DIV or MOD by zero.
REQ-015 The block SHALL have port err_valid, output, 1 bit: one-cycle pulse on a mismatch.
REQ-016 The block SHALL have port err_ptr, output, 5 bits: entry of the last mismatch.
REQ-017 The block SHALL have port err_expected, output, 64 bits: expected result of the last mismatch.
REQ-018 The block SHALL have port err_actual, output, 64 bits: stored result of the last mismatch.

Function
REQ-019 Opcode encoding SHALL be ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; codes 8..15 are illegal.
REQ-020 The FSM SHALL have states IDLE, WAIT and CHECK, plus a DONE state lasting one cycle.
REQ-021 In IDLE with start=1 and count>0, on the next edge the block SHALL:
- latch count
- set read_pointer=first_ptr and busy=1
- clear pass_cnt, fail_cnt and skip_cnt
- load the wait counter with READ_LAT, then enter WAIT.
REQ-022 WAIT SHALL decrement the wait counter each cycle and enter CHECK when it reaches 1, so instruction_word is sampled exactly READ_LAT cycles after read_pointer updates.
REQ-023 CHECK SHALL compute the expected result at 64 bits from the sign-extended operands a and b:
- ZERO: 0
- PASSA: a
- PASSB: b
- ADD: a+b
- SUB: a-b
- MULT: a*b (full signed 64-bit product)
- DIV: a/b (truncates toward zero)
- MOD: a%b (sign follows a)
REQ-024 In CHECK, on a match the block SHALL increment pass_cnt.
REQ-025 In CHECK, on a mismatch or an illegal opcode the block SHALL, in the same cycle:
- increment fail_cnt
- pulse err_valid
- load err_ptr, err_expected and err_actual (err_expected=0 for illegal opcodes).
REQ-026 DIV or MOD with operand_b=0 SHALL increment skip_cnt only, with no compare and no err_valid.
REQ-027 After CHECK, if entries remain, read_pointer SHALL increment modulo 32 (31 wraps to 0), the wait counter SHALL reload, and the FSM SHALL return to WAIT.
- Throughput: READ_LAT+1 cycles per entry.
REQ-028 After the last CHECK, the FSM SHALL go to DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
REQ-029 start with count=0 SHALL produce a done pulse on the next cycle, with busy staying 0 and counters cleared.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 pass_cnt, fail_cnt, skip_cnt and the err_* outputs SHALL hold their values in IDLE until the next accepted start.
REQ-032 pass_cnt+fail_cnt+skip_cnt SHALL equal the latched count when done pulses.

Reset
REQ-033 While reset_n=0 the block SHALL immediately force:
- FSM to IDLE
- read_pointer=0, busy=0, done=0, err_valid=0
- all counters=0, err_ptr=0, err_expected=0, err_actual=0.
REQ-034 Reset mid-sweep SHALL abandon the sweep with no done pulse; the first start after release SHALL begin a fresh sweep.

Verification
REQ-035 The bench SHALL cover: READ_LAT=2, first_ptr=0, count=3, entries {ADD 5,3,8}, {SUB 2,7,-5}, {MULT -4,6,-24} -> pass_cnt=3, fail_cnt=0, done at 10 cycles after start accepted.
REQ-036 The bench SHALL cover: entry 4 = {ADD 1,1,3}, first_ptr=4, count=1 -> err_valid one cycle, err_ptr=4, err_expected=2, err_actual=3, fail_cnt=1.
REQ-037 The bench SHALL cover: first_ptr=30, count=4 -> read_pointer sequence 30, 31, 0, 1; pass_cnt+fail_cnt+skip_cnt=4.
REQ-038 The bench SHALL cover: {DIV 9,0,x} and {MOD -7,2,-1} -> skip_cnt=1, pass_cnt=1, no err_valid.
REQ-039 The bench SHALL cover: reset_n low during the second entry of a count=5 sweep -> all outputs 0 immediately, no done pulse; a restart with count=2 completes normally.
REQ-040 The bench SHALL cover: start held high during a sweep, and start with count=0 -> the second start is ignored; count=0 gives a done pulse one cycle later with busy never 1.
